acumulador_produtos: RTL and testbench

ACUMULADOR_PRODUTOS -- requirements
Module: acumulador_produtos

---
 rtl/acumulador_produtos.sv | 121 ++++++++++++
 tb/tb_acumulador_produtos.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_produtos.sv
// Sums K products from an upstream multiplier, one per rising edge of finish, and
// offers the result on a valid/ready handshake. Define ACUMULADOR_SATURATE_EN to clamp on overflow.
module acumulador_produtos #(
   parameter int unsigned n = 8,
   parameter int unsigned K = 4,
   parameter int unsigned W = 2 * n + 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [2*n-1:0] P,
   input  logic           finish,
   output logic [W-1:0]   sum,
   output logic           sum_valid,
   input  logic           sum_ready,
   output logic           busy,
   output logic           lost,
   output logic           ovf
);

   localparam int unsigned CntW = $clog2(K);
   localparam logic [CntW-1:0] CntLast = CntW'(K - 1);

   typedef enum logic [1:0] {StIdle, StAcum, StHold} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [CntW-1:0] count_q, count_d;
   logic            finish_q;
   logic            sum_valid_q, sum_valid_d;
   logic            lost_q, lost_d;
   logic            ovf_q, ovf_d;

   logic            fin_edge;
   logic [W:0]      add_ext;
   logic            carry;

   always_comb begin
      fin_edge    = finish & ~finish_q;
      add_ext     = {1'b0, acc_q} + (W + 1)'(P);
      carry       = add_ext[W];

      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      sum_valid_d = sum_valid_q;
      lost_d      = lost_q;
      ovf_d       = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (fin_edge) lost_d = 1'b1;
            if (start) begin
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = StAcum;
            end
         end
         StAcum: begin
            // start is deliberately ignored here: a running sum is never restarted
            if (fin_edge) begin
               count_d = count_q + CntW'(1);
               if (carry) ovf_d = 1'b1;
`ifdef ACUMULADOR_SATURATE_EN
               if (carry || ovf_q) acc_d = '1;
               else                acc_d = add_ext[W-1:0];
`else
               acc_d = add_ext[W-1:0];
`endif
               if (count_q == CntLast) begin
                  state_d     = StHold;
                  sum_valid_d = 1'b1;
               end
            end
         end
         StHold: begin
            if (fin_edge) lost_d = 1'b1;
            if (sum_valid_q && sum_ready) begin
               sum_valid_d = 1'b0;
               if (start) begin
                  acc_d   = '0;
                  count_d = '0;
                  ovf_d   = 1'b0;
                  state_d = StAcum;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         count_q     <= '0;
         finish_q    <= 1'b0;
         sum_valid_q <= 1'b0;
         lost_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         finish_q    <= finish;
         sum_valid_q <= sum_valid_d;
         lost_q      <= lost_d;
         ovf_q       <= ovf_d;
      end
   end

   assign sum       = acc_q;
   assign sum_valid = sum_valid_q;
   assign busy      = (state_q == StAcum);
   assign lost      = lost_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_acumulador_produtos.sv
// Scoreboard bench for acumulador_produtos: a W=18 and a W=17 instance share stimulus;
// expected sums come from a bench-side accumulator model queued per transaction.
module tb_acumulador_produtos;

`ifdef ACUMULADOR_SATURATE_EN
   localparam bit Sat = 1'b1;
   localparam longint Exp17Ovf = 131071;
`else
   localparam bit Sat = 1'b0;
   localparam longint Exp17Ovf = 129028;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] P;
   logic        finish;
   logic        sum_ready;

   logic [17:0] sum18;
   logic        sv18, busy18, lost18, ovf18;
   logic [16:0] sum17;
   logic        sv17, busy17, lost17, ovf17;

   int passed = 0;
   int total  = 0;

   longint model18, model17;
   bit     movf18, movf17;
   longint q18[$], q17[$];
   bit     qovf18[$], qovf17[$];

   acumulador_produtos #(.n(8), .K(4)) dut (
      .clk(clk), .reset(reset), .start(start), .P(P), .finish(finish),
      .sum(sum18), .sum_valid(sv18), .sum_ready(sum_ready),
      .busy(busy18), .lost(lost18), .ovf(ovf18)
   );

   acumulador_produtos #(.n(8), .K(4), .W(17)) dut17 (
      .clk(clk), .reset(reset), .start(start), .P(P), .finish(finish),
      .sum(sum17), .sum_valid(sv17), .sum_ready(sum_ready),
      .busy(busy17), .lost(lost17), .ovf(ovf17)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic longint madd(input longint acc, input longint p, input int w);
      longint mx = (longint'(1) << w) - 1;
      longint s  = acc + p;
      if (s > mx) return Sat ? mx : s - (longint'(1) << w);
      return s;
   endfunction

   task automatic start_sum;
      start = 1'b1;
      tick();
      start   = 1'b0;
      model18 = 0;
      model17 = 0;
      movf18  = 1'b0;
      movf17  = 1'b0;
   endtask

   task automatic send_product(input longint p, input int hold);
      P      = 16'(p);
      finish = 1'b1;
      repeat (hold) tick();
      finish = 1'b0;
      tick();
   endtask

   task automatic feed(input longint p, input int hold);
      if (model18 + p > 262143) movf18 = 1'b1;
      if (model17 + p > 131071) movf17 = 1'b1;
      model18 = madd(model18, p, 18);
      model17 = madd(model17, p, 17);
      send_product(p, hold);
   endtask

   task automatic finish_sum;
      q18.push_back(model18);
      q17.push_back(model17);
      qovf18.push_back(movf18);
      qovf17.push_back(movf17);
   endtask

   task automatic wait_and_check(input string name);
      int i = 0;
      longint e18, e17;
      bit eo18, eo17;
      while (!sv18 && i < 30) begin
         tick();
         i++;
      end
      total++;
      if (!sv18) $display("FAIL %s_valid_timeout: sum_valid=%0b want 1", name, sv18);
      else passed++;
      e18 = q18.pop_front();
      e17 = q17.pop_front();
      eo18 = qovf18.pop_front();
      eo17 = qovf17.pop_front();
      total++;
      if (longint'(sum18) !== e18) $display("FAIL %s_sum18: got %0d want %0d", name, sum18, e18);
      else passed++;
      total++;
      if (ovf18 !== eo18) $display("FAIL %s_ovf18: got %0b want %0b", name, ovf18, eo18);
      else passed++;
      total++;
      if (longint'(sum17) !== e17 || sv17 !== 1'b1)
         $display("FAIL %s_sum17: got %0d/v%0b want %0d/v1", name, sum17, sv17, e17);
      else passed++;
      total++;
      if (ovf17 !== eo17) $display("FAIL %s_ovf17: got %0b want %0b", name, ovf17, eo17);
      else passed++;
   endtask

   task automatic handshake(input string name);
      sum_ready = 1'b1;
      tick();
      sum_ready = 1'b0;
      total++;
      if (sv18 !== 1'b0 || busy18 !== 1'b0)
         $display("FAIL %s_after_handshake: valid=%0b busy=%0b want 0/0", name, sv18, busy18);
      else passed++;
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; P = '0; finish = 1'b0; sum_ready = 1'b0;
      #3;
      total++;
      if (sum18 !== 18'd0 || sum17 !== 17'd0) $display("FAIL reset_sum: got %0d/%0d want 0", sum18, sum17);
      else passed++;
      total++;
      if ({sv18, busy18, lost18, ovf18} !== 4'b0)
         $display("FAIL reset_flags: got v%0b b%0b l%0b o%0b want 0", sv18, busy18, lost18, ovf18);
      else passed++;
      tick();
      reset = 1'b1;
      tick();
      total++;
      if (busy18 !== 1'b0 || sv18 !== 1'b0) $display("FAIL reset_idle: busy=%0b valid=%0b want 0", busy18, sv18);
      else passed++;
   endtask

   task automatic test_basic;
      start_sum();
      total++;
      if (busy18 !== 1'b1) $display("FAIL basic_busy: got %0b want 1", busy18);
      else passed++;
      feed(15, 1); feed(100, 1); feed(65025, 1); feed(0, 1);
      finish_sum();
      wait_and_check("basic");
      total++;
      if (sum18 !== 18'h0FE74) $display("FAIL basic_const: got %0d want 65140", sum18);
      else passed++;
      handshake("basic");
   endtask

   task automatic test_level_finish;
      start_sum();
      for (int i = 0; i < 4; i++) feed(1, 5);
      finish_sum();
      wait_and_check("level");
      total++;
      if (sum18 !== 18'd4) $display("FAIL level_const: got %0d want 4", sum18);
      else passed++;
      handshake("level");
   endtask

   task automatic test_overflow;
      start_sum();
      for (int i = 0; i < 4; i++) feed(65025, 1);
      finish_sum();
      wait_and_check("overflow");
      total++;
      if (longint'(sum17) !== Exp17Ovf || ovf17 !== 1'b1)
         $display("FAIL overflow_const17: got %0d ovf=%0b want %0d ovf=1", sum17, ovf17, Exp17Ovf);
      else passed++;
      handshake("overflow");
   endtask

   task automatic test_hold_stall;
      start_sum();
      feed(7, 1); feed(8, 1); feed(9, 1); feed(10, 1);
      finish_sum();
      wait_and_check("stall");
      total++;
      if (lost18 !== 1'b0) $display("FAIL stall_lost_before: got %0b want 0", lost18);
      else passed++;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            P = 16'd123;
            finish = 1'b1;
         end
         if (i == 5) finish = 1'b0;
         tick();
         total++;
         if (longint'(sum18) !== model18 || sv18 !== 1'b1)
            $display("FAIL stall_hold_%0d: got %0d/v%0b want %0d/v1", i, sum18, sv18, model18);
         else passed++;
      end
      total++;
      if (lost18 !== 1'b1 || lost17 !== 1'b1) $display("FAIL stall_lost: got %0b/%0b want 1", lost18, lost17);
      else passed++;
      handshake("stall");
   endtask

   task automatic test_back_to_back;
      start_sum();
      for (int i = 0; i < 4; i++) feed(5, 1);
      finish_sum();
      wait_and_check("b2b_first");
      sum_ready = 1'b1;
      start = 1'b1;
      tick();
      sum_ready = 1'b0;
      start = 1'b0;
      model18 = 0; model17 = 0; movf18 = 1'b0; movf17 = 1'b0;
      total++;
      if (busy18 !== 1'b1 || sv18 !== 1'b0 || sum18 !== 18'd0 || ovf17 !== 1'b0)
         $display("FAIL b2b_restart: busy=%0b valid=%0b sum=%0d ovf17=%0b want 1/0/0/0",
                  busy18, sv18, sum18, ovf17);
      else passed++;
      for (int i = 0; i < 4; i++) feed(2, 1);
      finish_sum();
      wait_and_check("b2b_second");
      total++;
      if (sum18 !== 18'd8) $display("FAIL b2b_const: got %0d want 8", sum18);
      else passed++;
      handshake("b2b");
   endtask

   task automatic test_reset_mid;
      start_sum();
      feed(1, 1); feed(1, 1);
      total++;
      if (busy18 !== 1'b1) $display("FAIL rstmid_busy: got %0b want 1", busy18);
      else passed++;
      #2 reset = 1'b0;
      #1;
      total++;
      if (sum18 !== 18'd0 || sum17 !== 17'd0 || {sv18, busy18, lost18, ovf18} !== 4'b0)
         $display("FAIL rstmid_async: sum=%0d/%0d v%0b b%0b l%0b o%0b want all 0",
                  sum18, sum17, sv18, busy18, lost18, ovf18);
      else passed++;
      tick();
      reset = 1'b1;
      tick();
      send_product(3, 1);
      send_product(3, 1);
      total++;
      if (lost18 !== 1'b1 || busy18 !== 1'b0 || sum18 !== 18'd0 || sv18 !== 1'b0)
         $display("FAIL rstmid_after: lost=%0b busy=%0b sum=%0d valid=%0b want 1/0/0/0",
                  lost18, busy18, sum18, sv18);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_level_finish();
      test_overflow();
      test_hold_stall();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
